// File: rtl/fifo_a_ram_1clk_if.sv
// fifo_a_ram_1clk_if: write/read port bundle for the audio sample ring buffer RAM.
interface fifo_a_ram_1clk_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8
);
   logic              wren;
   logic [ADDR_W-1:0] wraddress;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] rdaddress;
   logic [DATA_W-1:0] q;
   modport master (output wren, wraddress, data, rdaddress, input q);
   modport slave (input wren, wraddress, data, rdaddress, output q);
endinterface

// File: rtl/fifo_a_ram_1clk.sv
// fifo_a_ram_1clk: 256x128 simple dual-port block RAM, read-old-data, registered output.
// Define FIFO_A_RAM_OUTREG_EN to add a second output register (2-cycle read latency).
module fifo_a_ram_1clk #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 8
) (
   input logic               Clk,
   input logic               reset_n,
   fifo_a_ram_1clk_if.slave  bus
);
   logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
   logic [DATA_W-1:0] rd_q;
   // Array stays reset-free so it maps onto a block RAM; an X wren evaluates false.
   always_ff @(posedge Clk)
      if (reset_n && bus.wren) mem[bus.wraddress] <= bus.data;
   always_ff @(posedge Clk or negedge reset_n)
      if (!reset_n) rd_q <= '0;
      else rd_q <= mem[bus.rdaddress];
`ifdef FIFO_A_RAM_OUTREG_EN
   logic [DATA_W-1:0] out_q;
   always_ff @(posedge Clk or negedge reset_n)
      if (!reset_n) out_q <= '0;
      else out_q <= rd_q;
   assign bus.q = out_q;
`else
   assign bus.q = rd_q;
`endif
endmodule

// File: tb/tb_fifo_a_ram_1clk.sv
// tb_fifo_a_ram_1clk: directed self-checking bench for fifo_a_ram_1clk.
module tb_fifo_a_ram_1clk;
`ifdef FIFO_A_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam logic [127:0] ONES = {128{1'b1}};
   localparam logic [127:0] W00 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] WFF = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
   localparam logic [127:0] AAA = {32{4'hA}};
   localparam logic [127:0] FIV = {32{4'h5}};
   localparam logic [127:0] W20 = {4{32'h12345678}};
   logic Clk = 1'b0;
   logic reset_n = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   fifo_a_ram_1clk_if bus ();
   fifo_a_ram_1clk dut (.Clk(Clk), .reset_n(reset_n), .bus(bus));
   always #5 Clk = ~Clk;
   function automatic logic [127:0] pat(input logic [7:0] a);
      return {8{a, a}};
   endfunction
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge Clk);
      #1;
   endtask
   task automatic wr(input logic [7:0] a, input logic [127:0] d);
      bus.wren = 1'b1;
      bus.wraddress = a;
      bus.data = d;
      step();
      bus.wren = 1'b0;
   endtask
   task automatic rd(input string tag, input logic [7:0] a, input logic [127:0] exp);
      bus.rdaddress = a;
      repeat (LAT) step();
      check(tag, bus.q, exp);
   endtask
   initial begin
      bus.wren = 1'b1;
      bus.wraddress = 8'h05;
      bus.data = ONES;
      bus.rdaddress = 8'h05;
      #1 reset_n = 1'b0;
      #1 check("rst_async", bus.q, '0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_hold", bus.q, '0);
      end
      #3 reset_n = 1'b1;
      bus.wren = 1'b0;
      #1 check("rst_release", bus.q, '0);
      rd("rst_nowrite", 8'h05, bus.q);
      check("rst_not_ones", {127'd0, bus.q == ONES}, '0);
      wr(8'h00, W00);
      wr(8'hFF, WFF);
      rd("basic_00", 8'h00, W00);
      rd("basic_ff", 8'hFF, WFF);
      wr(8'h10, AAA);
      bus.wren = 1'b1;
      bus.wraddress = 8'h10;
      bus.data = FIV;
      bus.rdaddress = 8'h10;
      step();
      bus.wren = 1'b0;
      repeat (LAT - 1) step();
      check("rdw_old", bus.q, AAA);
      rd("rdw_new", 8'h10, FIV);
      wr(8'h20, W20);
      bus.wraddress = 8'h20;
      bus.data = ~W20;
      repeat (10) step();
      rd("wren_gate", 8'h20, W20);
      for (int i = 0; i < 256; i++) wr(8'(i), pat(8'(i)));
      for (int i = 0; i < 257 + LAT - 1; i++) begin
         bus.rdaddress = 8'(i);
         step();
         if (i >= LAT - 1) check($sformatf("sweep_%0d", i - (LAT - 1)), bus.q, pat(8'(i - (LAT - 1))));
      end
      rd("mid_pre", 8'h40, pat(8'h40));
      #2 reset_n = 1'b0;
      #1 check("mid_async", bus.q, '0);
      #2 reset_n = 1'b1;
      #1 check("mid_release", bus.q, '0);
      rd("mid_40", 8'h40, pat(8'h40));
      rd("mid_80", 8'h80, pat(8'h80));
      rd("mid_ff", 8'hFF, pat(8'hFF));
      rd("mid_00", 8'h00, pat(8'h00));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
